// File: rtl/mips_muldiv_unit_if.sv
// CPU <-> multiply/divide unit port bundle: request strobe, operands, status and HI/LO.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       fncode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, fncode, op_a, op_b, input busy, done, hi, lo);
    modport slave  (input start, fncode, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; iterative shift-add and restoring divide.
// Optional MULDIV_FAST_MULT_EN: single-cycle multiply in the MUL state.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic [WIDTH-1:0]     r_hi, r_lo, w_fix_hi, w_fix_lo;
    logic [WIDTH-1:0]     r_m, r_acc_hi, r_acc_lo, r_a_orig;
    logic                 r_is_div, r_neg_res, r_neg_rem, r_bzero;
    logic                 w_fn_mul, w_fn_div, w_signed, w_accept, w_idle_wr;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_ge;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_fn_mul  = (bus.fncode == FN_MULT) || (bus.fncode == FN_MULTU);
    assign w_fn_div  = (bus.fncode == FN_DIV)  || (bus.fncode == FN_DIVU);
    assign w_signed  = ~bus.fncode[0];
    assign w_idle_wr = (r_state == S_IDLE) && bus.start;
    assign w_accept  = w_idle_wr && (w_fn_mul || w_fn_div);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_fn_div ? S_DIV : S_MUL;
`ifdef MULDIV_FAST_MULT_EN
            S_MUL:  w_state_nxt = S_FIX;
`else
            S_MUL:  if (r_cnt == '0) w_state_nxt = S_FIX;
`endif
            S_DIV:  if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_FIX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept)           r_cnt <= CW'(WIDTH - 1);
            else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
            if (w_idle_wr && bus.fncode == FN_MTHI) r_hi <= bus.op_a;
            if (w_idle_wr && bus.fncode == FN_MTLO) r_lo <= bus.op_a;
            if (r_state == S_FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

    // Restoring divide step: partial remainder in r_acc_hi, dividend/quotient shifting through r_acc_lo
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_m};
    assign w_ge    = ~w_trial[WIDTH+1];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast;
    assign w_fast = {{WIDTH{1'b0}}, r_m} * {{WIDTH{1'b0}}, r_acc_lo};
`else
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
`endif

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (w_accept) begin
                r_is_div  <= w_fn_div;
                r_a_orig  <= bus.op_a;
                r_bzero   <= (bus.op_b == '0);
                r_neg_res <= w_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                r_neg_rem <= w_signed & bus.op_a[WIDTH-1];
                r_acc_hi  <= '0;
                if (w_fn_div) begin
                    r_m      <= f_mag(bus.op_b, w_signed);
                    r_acc_lo <= f_mag(bus.op_a, w_signed);
                end else begin
                    r_m      <= f_mag(bus.op_a, w_signed);
                    r_acc_lo <= f_mag(bus.op_b, w_signed);
                end
            end
`ifdef MULDIV_FAST_MULT_EN
            S_MUL: {r_acc_hi, r_acc_lo} <= w_fast;
`else
            S_MUL: {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[WIDTH-1:1]};
`endif
            S_DIV: begin
                r_acc_hi <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
            end
            default: ;
        endcase
    end

    // Sign fix-up; divide by zero returns the raw dividend in HI regardless of signedness
    assign w_prod = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_bzero) begin
                w_fix_hi = r_a_orig;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = f_cond_neg(r_acc_hi, r_neg_rem);
                w_fix_lo = f_cond_neg(r_acc_lo, r_neg_res);
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: directed vector table, corner sequences, and random ops vs arithmetic model.
module tb_mips_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mips_muldiv_unit_if #(.WIDTH(W)) bus();
    mips_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] m_hi, m_lo;

    typedef struct {
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        logic [W-1:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            F_MULT:  begin p = sa * sb; return p; end
            F_MULTU: return {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            F_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string tag);
        logic [W-1:0] pre_hi, pre_lo;
        int k, lat;
        bit busy_ok, hold_ok;
        lat = (fn == F_MULT || fn == F_MULTU) ? MUL_LAT : DIV_LAT;
        @(negedge clk);
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        bus.start = 1'b1; bus.fncode = fn; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        chk({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        busy_ok = 1; hold_ok = 1; k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) hold_ok = 0;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " busy_span"}, 64'(busy_ok), 64'd1);
        chk({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic run_mt(input logic [5:0] fn, input logic [W-1:0] a, input string tag);
        @(negedge clk);
        bus.start = 1'b1; bus.fncode = fn; bus.op_a = a;
        @(negedge clk);
        bus.start = 1'b0;
        if (fn == F_MTHI) m_hi = a; else m_lo = a;
        chk({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
        chk({tag, " no_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " no_done"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[10];
    logic [63:0] e;
    logic [5:0] fns[6];
    logic [W-1:0] pre_hi, pre_lo, ra, rb;
    int k;
    bit hold_ok;

    initial begin
        vecs[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{F_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
        vecs[5] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{F_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[7] = '{F_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        vecs[8] = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9] = '{F_MULTU, 32'd0,         32'h1234_5678, 32'd0,         32'd0};
        fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.fncode = 6'h0; bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        run_mt(F_MTHI, 32'h0000_1234, "mthi");
        run_mt(F_MTLO, 32'hCAFE_0001, "mtlo");

        // Unsupported funct with start must do nothing
        @(negedge clk);
        bus.start = 1'b1; bus.fncode = 6'h20; bus.op_a = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        chk("badfn busy", 64'(bus.busy), 64'd0);
        chk("badfn hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        // Strobes during a divide are ignored
        @(negedge clk);
        pre_hi = bus.hi; pre_lo = bus.lo;
        bus.start = 1'b1; bus.fncode = F_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        @(negedge clk);
        k = 0; hold_ok = 1;
        while (bus.done !== 1'b1 && k < 100) begin
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) hold_ok = 0;
            bus.start  = (k == 4 || k == 5);
            bus.fncode = (k == 4) ? F_MTLO : F_MULT;
            bus.op_a   = 32'hDEAD_BEEF;
            bus.op_b   = 32'd5;
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk("busydiv hold", 64'(hold_ok), 64'd1);
        chk("busydiv latency", 64'(k), 64'(DIV_LAT));
        chk("busydiv lo", 64'(bus.lo), 64'd142);
        chk("busydiv hi", 64'(bus.hi), 64'd6);
        @(negedge clk);
        chk("busydiv no_restart", 64'(bus.busy), 64'd0);
        chk("busydiv lo_kept", 64'(bus.lo), 64'd142);
        m_hi = 32'd6; m_lo = 32'd142;

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [5:0] fn;
            fn = fns[$urandom_range(0, 5)];
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'(($urandom_range(1, 15)));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            if (fn == F_MTHI || fn == F_MTLO) begin
                run_mt(fn, ra, $sformatf("rnd%0d", i));
            end else begin
                e = ref_calc(fn, ra, rb);
                run_op(fn, ra, rb, e[63:32], e[31:0], $sformatf("rnd%0d", i));
            end
        end

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.fncode = F_DIV; bus.op_a = 32'h7FFF_FFFF; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst hi", 64'(bus.hi), 64'd0);
        chk("midrst lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        chk("postrst idle", 64'({bus.busy, bus.done}), 64'd0);
        run_op(F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "postrst_multu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
